draw_scheduler: RTL and testbench

Frame-level drawing sequencer that sits between the game FSM and the VGA adapter. It is the initiator side of the drawing-client `enable`/`done` handshake. Drawing clients such as the score/time, hook and gold renderers are responders. On each frame tick the scheduler:
- clears the screen,
- enables each of four drawing clients in turn,
- forwards the active client's `outX`/`outY`/`color`/`writeEn` stream to the single VGA write port.

Clients that hang are aborted by a timeout.

---
 rtl/draw_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_draw_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// Frame sequencer: clears the screen, then runs each masked drawing client in turn and
// muxes the active client's pixel stream onto a single registered VGA write port.
module draw_scheduler #(
  parameter int unsigned CLEAR_W     = 320,
  parameter int unsigned CLEAR_H     = 240,
  parameter logic [11:0] CLEAR_COLOR = 12'h000,
  parameter int unsigned TIMEOUT     = 200000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        frame_tick,
  input  logic [3:0]  client_mask,
  input  logic [3:0]  client_done,
  input  logic [35:0] client_x,
  input  logic [31:0] client_y,
  input  logic [47:0] client_color,
  input  logic [3:0]  client_we,
  output logic [3:0]  client_enable,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [11:0] vga_color,
  output logic        vga_we,
  output logic        busy,
  output logic        frame_done,
  output logic [3:0]  timeout_flags,
  output logic        overrun
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [8:0] XLast = 9'(CLEAR_W - 1);
  localparam logic [7:0] YLast = 8'(CLEAR_H - 1);
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SELECT, S_ENABLE, S_WAIT, S_FRAME_DONE
  } state_e;

  state_e r_state, w_state_next;
  logic [3:0]    r_mask, w_mask_next;
  logic          r_pending, w_pending_next;
  logic          r_overrun, w_overrun_next;
  logic [3:0]    r_tflags, w_tflags_next;
  logic [2:0]    r_k, w_k_next;
  logic [8:0]    r_cx, w_cx_next;
  logic [7:0]    r_cy, w_cy_next;
  logic [TW-1:0] r_tcnt, w_tcnt_next;
  logic [8:0]    r_vga_x, w_pix_x;
  logic [7:0]    r_vga_y, w_pix_y;
  logic [11:0]   r_vga_color, w_pix_color;
  logic          r_vga_we, w_pix_we;
  logic [1:0]    w_idx;
  logic [8:0]    w_xs [4];
  logic [7:0]    w_ys [4];
  logic [11:0]   w_cs [4];

  assign w_idx = r_k[1:0];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_xs[i] = client_x[9*i +: 9];
      w_ys[i] = client_y[8*i +: 8];
      w_cs[i] = client_color[12*i +: 12];
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_mask_next    = r_mask;
    w_pending_next = r_pending;
    w_overrun_next = r_overrun;
    w_tflags_next  = r_tflags;
    w_k_next       = r_k;
    w_cx_next      = r_cx;
    w_cy_next      = r_cy;
    w_tcnt_next    = r_tcnt;
    w_pix_we       = 1'b0;
    w_pix_x        = r_vga_x;
    w_pix_y        = r_vga_y;
    w_pix_color    = r_vga_color;

    // One-deep tick queue while a frame is in flight; a second queued tick is an overrun.
    if (r_state != S_IDLE && frame_tick) begin
      if (r_pending) w_overrun_next = 1'b1;
      else           w_pending_next = 1'b1;
    end

    unique case (r_state)
      S_IDLE: begin
        if (frame_tick || r_pending) begin
          w_mask_next    = client_mask;
          w_pending_next = 1'b0;
          w_k_next       = 3'd0;
          w_cx_next      = 9'd0;
          w_cy_next      = 8'd0;
          w_state_next   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_pix_we    = 1'b1;
        w_pix_x     = r_cx;
        w_pix_y     = r_cy;
        w_pix_color = CLEAR_COLOR;
        if (r_cx == XLast) begin
          w_cx_next = 9'd0;
          if (r_cy == YLast) begin
            w_cy_next    = 8'd0;
            w_state_next = S_SELECT;
          end else begin
            w_cy_next = r_cy + 8'd1;
          end
        end else begin
          w_cx_next = r_cx + 9'd1;
        end
      end
      S_SELECT: begin
        if (r_k == 3'd4)          w_state_next = S_FRAME_DONE;
        else if (!r_mask[w_idx])  w_k_next = r_k + 3'd1;
        else                      w_state_next = S_ENABLE;
      end
      S_ENABLE: begin
        w_tcnt_next  = '0;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (client_we[w_idx]) begin
          w_pix_we    = 1'b1;
          w_pix_x     = w_xs[w_idx];
          w_pix_y     = w_ys[w_idx];
          w_pix_color = w_cs[w_idx];
        end
        if (client_done[w_idx]) begin
          w_k_next     = r_k + 3'd1;
          w_state_next = S_SELECT;
        end else if (r_tcnt == TLast) begin
          w_tflags_next[w_idx] = 1'b1;
          w_k_next             = r_k + 3'd1;
          w_state_next         = S_SELECT;
        end else begin
          w_tcnt_next = r_tcnt + 1'b1;
        end
      end
      S_FRAME_DONE: w_state_next = S_IDLE;
      default:      w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_pending   <= 1'b0;
      r_overrun   <= 1'b0;
      r_tflags    <= '0;
      r_k         <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_tcnt      <= '0;
      r_vga_x     <= '0;
      r_vga_y     <= '0;
      r_vga_color <= '0;
      r_vga_we    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mask      <= w_mask_next;
      r_pending   <= w_pending_next;
      r_overrun   <= w_overrun_next;
      r_tflags    <= w_tflags_next;
      r_k         <= w_k_next;
      r_cx        <= w_cx_next;
      r_cy        <= w_cy_next;
      r_tcnt      <= w_tcnt_next;
      r_vga_x     <= w_pix_x;
      r_vga_y     <= w_pix_y;
      r_vga_color <= w_pix_color;
      r_vga_we    <= w_pix_we;
    end
  end

  assign client_enable = (r_state == S_ENABLE) ? (4'b0001 << w_idx) : 4'b0000;
  assign busy          = (r_state != S_IDLE) && (r_state != S_FRAME_DONE);
  assign frame_done    = (r_state == S_FRAME_DONE);
  assign vga_x         = r_vga_x;
  assign vga_y         = r_vga_y;
  assign vga_color     = r_vga_color;
  assign vga_we        = r_vga_we;
  assign timeout_flags = r_tflags;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: directed frames with literal expectations, then random traffic,
// all outputs checked every cycle against a frame-progress model.
module tb_draw_scheduler;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int TO = 16;
  localparam logic [11:0] CC = 12'h000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_tick = 1'b0;
  logic [3:0]  client_mask = '0;
  logic [3:0]  client_done = '0;
  logic [35:0] client_x = '0;
  logic [31:0] client_y = '0;
  logic [47:0] client_color = '0;
  logic [3:0]  client_we = '0;
  logic [3:0]  client_enable;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [11:0] vga_color;
  logic        vga_we;
  logic        busy;
  logic        frame_done;
  logic [3:0]  timeout_flags;
  logic        overrun;

  always #5 clk = ~clk;

  draw_scheduler #(
    .CLEAR_W(W), .CLEAR_H(H), .CLEAR_COLOR(CC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .client_mask(client_mask),
    .client_done(client_done), .client_x(client_x), .client_y(client_y),
    .client_color(client_color), .client_we(client_we), .client_enable(client_enable),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_we(vga_we), .busy(busy),
    .frame_done(frame_done), .timeout_flags(timeout_flags), .overrun(overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: frame progress as phase + clear pixel index + current client + wait length.
  localparam int PH_IDLE = 0, PH_CLEAR = 1, PH_PICK = 2, PH_KICK = 3, PH_WAIT = 4, PH_END = 5;
  int ph, cl, pix, wcnt;
  logic [3:0]  mmask, tf;
  logic        pend, ovr, e_we;
  logic [8:0]  e_x;
  logic [7:0]  e_y;
  logic [11:0] e_c;

  task automatic model_reset();
    ph = PH_IDLE; cl = 0; pix = 0; wcnt = 0;
    mmask = '0; tf = '0; pend = 1'b0; ovr = 1'b0;
    e_we = 1'b0; e_x = '0; e_y = '0; e_c = '0;
  endtask

  function automatic logic [40:0] model_out();
    logic [3:0] en;
    en = (ph == PH_KICK) ? 4'(1 << cl) : 4'b0000;
    return {en, e_x, e_y, e_c, e_we, (ph >= PH_CLEAR && ph <= PH_WAIT), (ph == PH_END), tf, ovr};
  endfunction

  task automatic model_step();
    if (ph != PH_IDLE && frame_tick) begin
      if (pend) ovr = 1'b1;
      else      pend = 1'b1;
    end
    e_we = 1'b0;
    case (ph)
      PH_IDLE: if (frame_tick || pend) begin
        mmask = client_mask; pend = 1'b0; cl = 0; pix = 0; ph = PH_CLEAR;
      end
      PH_CLEAR: begin
        e_we = 1'b1; e_x = 9'(pix % W); e_y = 8'(pix / W); e_c = CC;
        pix++;
        if (pix == W * H) ph = PH_PICK;
      end
      PH_PICK: begin
        if (cl == 4)           ph = PH_END;
        else if (!mmask[cl])   cl++;
        else                   ph = PH_KICK;
      end
      PH_KICK: begin wcnt = 0; ph = PH_WAIT; end
      PH_WAIT: begin
        wcnt++;
        if (client_we[cl]) begin
          e_we = 1'b1;
          e_x = client_x[9*cl +: 9]; e_y = client_y[8*cl +: 8]; e_c = client_color[12*cl +: 12];
        end
        if (client_done[cl]) begin
          cl++; ph = PH_PICK;
        end else if (wcnt == TO) begin
          tf[cl] = 1'b1; cl++; ph = PH_PICK;
        end
      end
      PH_END: ph = PH_IDLE;
      default: ph = PH_IDLE;
    endcase
  endtask

  always @(negedge clk) begin
    if (!resetn) model_reset();
    check("cycle", {client_enable, vga_x, vga_y, vga_color, vga_we, busy, frame_done,
                    timeout_flags, overrun}, model_out());
    if (resetn) model_step();
  end

  // Driver / observer, runs #1 after each rising edge.
  int cyc = 0;
  int t_cyc = 0;
  int fd_cyc = 0;
  int fd_count = 0;
  bit rnd = 1'b0;
  logic [3:0] noise = '0;
  int dly[4];
  int due[4];
  int en_q[$];
  logic [28:0] px_q[$];
  int px_cyc[$];

  task automatic step();
    logic [3:0] we, dn;
    @(posedge clk);
    #1;
    cyc++;
    if (vga_we) begin
      px_q.push_back({vga_x, vga_y, vga_color});
      px_cyc.push_back(cyc);
    end
    if (frame_done) begin fd_count++; fd_cyc = cyc; end
    for (int k = 0; k < 4; k++) begin
      if (client_enable[k]) begin
        en_q.push_back(k);
        if (rnd)              due[k] = cyc + int'($urandom_range(1, 20));
        else if (dly[k] < 0)  due[k] = -1;
        else                  due[k] = cyc + dly[k];
      end
    end
    for (int k = 0; k < 4; k++) begin
      we[k] = noise[k] | (cyc == due[k]);
      dn[k] = noise[k] | (cyc == due[k]);
      if (rnd) begin
        we[k] = we[k] | ($urandom_range(0, 7) == 0);
        dn[k] = dn[k] | ($urandom_range(0, 29) == 0);
      end
    end
    client_we   = we;
    client_done = dn;
    if (rnd) begin
      frame_tick   = ($urandom_range(0, 49) == 0);
      client_mask  = 4'($urandom);
      client_x     = {4'($urandom), $urandom};
      client_y     = $urandom;
      client_color = {16'($urandom), $urandom};
    end else begin
      frame_tick   = 1'b0;
      client_x     = {9'd13, 9'd12, 9'd11, 9'd10};
      client_y     = {8'd23, 8'd22, 8'd21, 8'd20};
      client_color = {12'hF03, 12'hF02, 12'hF01, 12'hF00};
    end
  endtask

  task automatic tick(input logic [3:0] mask);
    client_mask = mask;
    frame_tick  = 1'b1;
    t_cyc       = cyc;
    px_q.delete(); px_cyc.delete(); en_q.delete();
  endtask

  task automatic wait_fd(input int budget);
    int start;
    bit got;
    start = fd_count;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (fd_count != start) got = 1'b1;
    end
    if (!got) check("frame_done_wait_expired", 0, 1);
  endtask

  initial begin
    int f, n0;
    for (int k = 0; k < 4; k++) begin dly[k] = 5; due[k] = -1; end
    repeat (3) step();
    resetn = 1'b1;
    step();
    check("reset_outputs", {client_enable, vga_x, vga_y, vga_color, vga_we, busy, frame_done,
                            timeout_flags, overrun}, 0);

    // Reset during the third clear cycle.
    tick(4'hF);
    repeat (3) step();
    resetn = 1'b0;
    #1;
    check("reset_mid_clear", {client_enable, vga_x, vga_y, vga_color, vga_we, busy, frame_done,
                              timeout_flags, overrun}, 0);
    repeat (2) step();
    resetn = 1'b1;
    px_q.delete();
    repeat (20) step();
    check("reset_then_no_we", px_q.size(), 0);
    check("reset_then_idle", busy, 0);

    // Clear only.
    tick(4'b0000);
    wait_fd(100);
    check("clear_len", fd_cyc - t_cyc, 14);
    check("clear_npix", px_q.size(), W * H);
    for (int i = 0; i < W * H && i < px_q.size(); i++)
      check("clear_pix", px_q[i], {9'(i % W), 8'(i / W), 12'h000});
    step();

    // Full frame, done 5 cycles after enable.
    n0 = fd_count;
    tick(4'b1111);
    wait_fd(200);
    check("full_len", fd_cyc - t_cyc, 38);
    check("full_nen", en_q.size(), 4);
    for (int k = 0; k < 4 && k < en_q.size(); k++) check("full_en_order", en_q[k], k);
    check("full_npix", px_q.size(), 12);
    for (int k = 0; k < 4 && 8 + k < px_q.size(); k++) begin
      check("full_client_pix", px_q[8+k], {9'(10 + k), 8'(20 + k), 12'hF00 | 12'(k)});
      check("full_pix_latency", px_cyc[8+k] - t_cyc, 16 + 7 * k);
    end
    repeat (5) step();
    check("full_one_done", fd_count - n0, 1);
    check("full_no_timeout", timeout_flags, 4'b0000);

    // Masking: client 1 is noisy but masked off.
    for (int k = 0; k < 4; k++) dly[k] = 3;
    noise = 4'b0010;
    tick(4'b0101);
    wait_fd(200);
    check("mask_len", fd_cyc - t_cyc, 22);
    check("mask_nen", en_q.size(), 2);
    if (en_q.size() == 2) begin
      check("mask_en0", en_q[0], 0);
      check("mask_en1", en_q[1], 2);
    end
    n0 = 0;
    foreach (px_q[i]) if (px_q[i][28:20] == 9'd11) n0++;
    check("mask_isolation", n0, 0);
    noise = '0;
    step();

    // Timeout of client 1.
    dly[1] = -1;
    tick(4'b0010);
    wait_fd(200);
    check("timeout_len", fd_cyc - t_cyc, 31);
    check("timeout_flag", timeout_flags, 4'b0010);
    dly[1] = 5;
    step();
    tick(4'b0000);
    wait_fd(100);
    check("timeout_sticky", timeout_flags, 4'b0010);
    step();

    // Pending and overrun.
    check("overrun_clear", overrun, 0);
    n0 = fd_count;
    tick(4'b0000);
    repeat (3) step();
    frame_tick = 1'b1;
    repeat (2) step();
    frame_tick = 1'b1;
    step();
    check("overrun_set", overrun, 1);
    wait_fd(100);
    f = fd_cyc;
    step();
    check("pending_gap_idle", busy, 0);
    step();
    check("pending_rerise", busy, 1);
    check("pending_rerise_cycle", cyc - f, 2);
    wait_fd(100);
    repeat (30) step();
    check("pending_two_frames", fd_count - n0, 2);
    check("pending_then_idle", busy, 0);

    // Random traffic, one reset in the middle.
    rnd = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      step();
      if (i == 2000) begin
        resetn = 1'b0;
        step();
        resetn = 1'b1;
      end
    end
    rnd = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
